multicycle_controller: RTL and testbench

//   Main control FSM for the multicycle RV32I-subset datapath, directly upstream of the ALU.

---
 rtl/multicycle_controller.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I-subset datapath (Fetch/Decode/Execute/Memory/Writeback).
// Define ILLEGAL_TRAP_EN to build the TRAP state; otherwise unknown opcodes retire as NOPs.
module multicycle_controller #(
  parameter int MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] o_dbg_state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP     = 4'd11;
`endif

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  logic [3:0] r_state;
  logic [2:0] r_wait;
  logic [3:0] w_next;
  logic [3:0] w_state;
  logic       w_wait_done;
  logic       w_holding;
  logic [2:0] w_alu_func;

  assign w_wait_done = (r_wait == LAT);
  assign w_holding   = ((r_state == S_FETCH) || (r_state == S_MEMREAD)) && !w_wait_done;
  // Outputs during reset read as FETCH, with the strobes masked further down.
  assign w_state     = reset ? S_FETCH : r_state;
  assign o_dbg_state = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (w_wait_done) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (w_wait_done) w_next = S_MEMWB;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = S_FETCH;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wait  <= 3'd0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_holding ? (r_wait + 3'd1) : 3'd0;
    end
  end

  always_comb begin
    w_alu_func = 3'b000;
    case (funct3)
      3'b000:  w_alu_func = (op[5] && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  w_alu_func = 3'b101;
      3'b110:  w_alu_func = 3'b011;
      3'b111:  w_alu_func = 3'b010;
      default: w_alu_func = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    RegWrite   = 1'b0;
    illegal    = 1'b0;
    case (w_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = w_wait_done;
        PCWrite   = w_wait_done;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = w_alu_func;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = w_alu_func;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        PCWrite    = Zero;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     illegal = 1'b1;
`endif
      default: ;
    endcase
    if (reset) begin
      PCWrite = 1'b0;
      IRWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller at MEM_LAT=0 and MEM_LAT=2.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;

  logic       pcw0, adr0, mw0, irw0, rw0, ill0;
  logic [1:0] rs0, sa0, sb0, imm0;
  logic [2:0] alu0;
  logic [3:0] st0;
  logic       pcw1, adr1, mw1, irw1, rw1, ill1;
  logic [1:0] rs1, sa1, sb1, imm1;
  logic [2:0] alu1;
  logic [3:0] st1;

  logic [16:0] exp_q[$];
  string       tag_q[$];
  int          cur = 0;
  int          lat = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_LAT(0)) dut0 (
    .clk(clk), .reset(rst0), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .ResultSrc(rs0),
    .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUControl(alu0), .ImmSrc(imm0), .RegWrite(rw0),
    .illegal(ill0), .o_dbg_state(st0)
  );

  multicycle_controller #(.MEM_LAT(2)) dut1 (
    .clk(clk), .reset(rst1), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
    .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1), .ResultSrc(rs1),
    .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUControl(alu1), .ImmSrc(imm1), .RegWrite(rw1),
    .illegal(ill1), .o_dbg_state(st1)
  );

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, illegal}
  logic [16:0] w_word0, w_word1, w_word;
  assign w_word0 = {pcw0, adr0, mw0, irw0, rs0, sa0, sb0, alu0, imm0, rw0, ill0};
  assign w_word1 = {pcw1, adr1, mw1, irw1, rs1, sa1, sb1, alu1, imm1, rw1, ill1};
  assign w_word  = (cur == 0) ? w_word0 : w_word1;

  // ---------------- reference model ----------------
  function automatic logic [2:0] alu_of(logic [6:0] o, logic [2:0] f3, logic f7);
    if (f3 == 3'd0) return (o[5] && f7) ? 3'd1 : 3'd0;
    if (f3 == 3'd2) return 3'd5;
    if (f3 == 3'd6) return 3'd3;
    if (f3 == 3'd7) return 3'd2;
    return 3'd0;
  endfunction

  function automatic logic [1:0] imm_of(logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [16:0] word_of(string ph, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0;
    logic [2:0] alu = 0;
    case (ph)
      "RST", "F": begin sb = 2'b10; rs = 2'b10; end
      "FL":   begin sb = 2'b10; rs = 2'b10; irw = 1; pcw = 1; end
      "D":    begin sa = 2'b01; sb = 2'b01; end
      "MA":   begin sa = 2'b10; sb = 2'b01; end
      "MR":   adr = 1;
      "MWB":  begin rs = 2'b01; rw = 1; end
      "MW":   begin adr = 1; mw = 1; end
      "ER":   begin sa = 2'b10; alu = alu_of(o, f3, f7); end
      "EI":   begin sa = 2'b10; sb = 2'b01; alu = alu_of(o, f3, f7); end
      "AWB":  rw = 1;
      "BEQ":  begin sa = 2'b10; alu = 3'd1; pcw = z; end
      "JAL":  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      "TRAP": ill = 1;
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm_of(o), rw, ill};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rst(input logic v);
    if (cur == 0) rst0 = v; else rst1 = v;
  endtask

  task automatic do_reset(input int n);
    set_rst(1'b1);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(word_of("RST", op, funct3, funct7b5, zero));
      tag_q.push_back("reset");
    end
    wait_cyc(n);
    set_rst(1'b0);
  endtask

  // Issues one instruction; only the first maxc cycles are expected/waited.
  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int maxc);
    string ph_q[$];
    int n;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    for (int i = 0; i < lat; i++) ph_q.push_back("F");
    ph_q.push_back("FL");
    ph_q.push_back("D");
    case (o)
      7'b0000011: begin
        ph_q.push_back("MA");
        for (int i = 0; i <= lat; i++) ph_q.push_back("MR");
        ph_q.push_back("MWB");
      end
      7'b0100011: begin ph_q.push_back("MA"); ph_q.push_back("MW"); end
      7'b0110011: begin ph_q.push_back("ER"); ph_q.push_back("AWB"); end
      7'b0010011: begin ph_q.push_back("EI"); ph_q.push_back("AWB"); end
      7'b1100011: ph_q.push_back("BEQ");
      7'b1101111: begin ph_q.push_back("JAL"); ph_q.push_back("AWB"); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) ph_q.push_back("TRAP");
`endif
      end
    endcase
    n = (maxc < ph_q.size()) ? maxc : ph_q.size();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(word_of(ph_q[i], o, f3, f7, z));
      tag_q.push_back(ph_q[i]);
    end
    wait_cyc(n);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [16:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (w_word !== e) begin
        bad++;
        $display("FAIL ctl_%s dut%0d got=%05h exp=%05h", t, cur, w_word, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] ops [7];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1111111};
    rst0 = 1'b1; rst1 = 1'b1;
    op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
    wait_cyc(2);
    for (int d = 0; d < 2; d++) begin
      cur = d;
      lat = (d == 0) ? 0 : 2;
      do_reset(2);
      issue(7'b0000011, 3'd2, 1'b0, 1'b0, 99);           // lw
      issue(7'b0110011, 3'd0, 1'b1, 1'b0, 99);           // sub
      issue(7'b0110011, 3'd0, 1'b0, 1'b0, 99);           // add
      issue(7'b0110011, 3'd6, 1'b0, 1'b0, 99);           // or
      issue(7'b0110011, 3'd2, 1'b0, 1'b0, 99);           // slt
      issue(7'b0110011, 3'd7, 1'b0, 1'b0, 99);           // and
      issue(7'b0010011, 3'd0, 1'b1, 1'b0, 99);           // addi, f7b5 ignored
      issue(7'b0100011, 3'd2, 1'b0, 1'b0, 99);           // sw
      issue(7'b1100011, 3'd0, 1'b0, 1'b1, 99);           // beq taken
      issue(7'b1100011, 3'd0, 1'b0, 1'b0, 99);           // beq not taken
      issue(7'b1101111, 3'd0, 1'b0, 1'b0, 99);           // jal
      for (int k = 0; k < 30; k++) begin
        int idx;
`ifdef ILLEGAL_TRAP_EN
        idx = $urandom_range(0, 5);
`else
        idx = $urandom_range(0, 6);
`endif
        issue(ops[idx], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 99);
      end
      // Abort a load in its first MEMREAD cycle, then recover.
      issue(7'b0000011, 3'd2, 1'b0, 1'b0, lat + 4);
      do_reset(3);
      issue(7'b0010011, 3'd6, 1'b0, 1'b0, 99);
      issue(7'b1111111, 3'd0, 1'b0, 1'b0, 99);           // unknown opcode
      do_reset(2);
      issue(7'b0000011, 3'd2, 1'b0, 1'b0, 99);
      set_rst(1'b1);
    end
    wait_cyc(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain left=%0d need=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
